wb_arb: RTL

Parametrised writeback arbiter between the execute-stage result channels and the reorder buffer. It generalises the fixed four-channel EX→WB register stage (alu / forwarder / jump / branch) to `NCH` producer channels. Each channel has a `DEPTH`-entry FIFO, and up to `NWP` results per cycle go to the ROB write ports under round-robin arbitration. It supports global stall and mispredict flush. It sits between the functional units and `rob`.

---
 rtl/wb_arb.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/wb_arb.sv
`default_nettype none
// ============================================================================
// wb_arb : NCH-channel EX->WB arbiter with per-channel FIFOs feeding NWP ROB
//          write ports under round-robin; define WB_ARB_BYPASS_EN for bypass.
// Revision: 1.0
// ============================================================================
module wb_arb #(
  parameter int NCH    = 4,
  parameter int NWP    = 2,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 33,
  localparam int CH_W  = $clog2(NCH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          in_valid,
  output logic [NCH-1:0]          in_ready,
  input  logic [NCH*TAG_W-1:0]    in_tag,
  input  logic [NCH*DATA_W-1:0]   in_data,
  input  logic [NCH*CTRL_W-1:0]   in_ctrl,
  input  logic                    wb_stall,
  input  logic                    flush,
  output logic [NWP-1:0]          out_valid,
  output logic [NWP*TAG_W-1:0]    out_tag,
  output logic [NWP*DATA_W-1:0]   out_data,
  output logic [NWP*CTRL_W-1:0]   out_ctrl,
  output logic [NWP*CH_W-1:0]     out_ch
);

  localparam int E_W   = TAG_W + DATA_W + CTRL_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef WB_ARB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [E_W-1:0]   in_entry   [NCH];
  logic [E_W-1:0]   head_entry [NCH];
  logic [CNT_W-1:0] count      [NCH];
  logic [PTR_W-1:0] head       [NCH];
  logic [PTR_W-1:0] tail       [NCH];
  logic [NCH-1:0]   avail;
  logic [NCH-1:0]   grant;
  logic [NCH-1:0]   enq;
  logic [NCH-1:0]   deq;

  logic [CH_W-1:0]  scan_ch    [NCH];
  logic [NWP-1:0]   port_vld;
  logic [CH_W-1:0]  port_ch    [NWP];
  logic [E_W-1:0]   sel_entry  [NWP];
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  rr_next;
  logic [CH_W-1:0]  last_ch;
  logic             any_grant;
  logic             arb_en;

  assign arb_en = !wb_stall && !flush;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Per-channel circular FIFOs
  // ---------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [E_W-1:0] mem [DEPTH];

      assign in_entry[i] = {in_tag[i*TAG_W +: TAG_W],
                            in_data[i*DATA_W +: DATA_W],
                            in_ctrl[i*CTRL_W +: CTRL_W]};

      // Registered count only: no path from dequeue or stall into ready.
      assign in_ready[i] = rst && (count[i] < CNT_W'(DEPTH));

      assign avail[i] = (count[i] != '0) ||
                        (BYPASS && in_valid[i] && in_ready[i]);

      // A granted beat on an empty FIFO went straight out and is not stored.
      assign enq[i] = in_valid[i] && in_ready[i] && !flush &&
                      !(grant[i] && (count[i] == '0));
      assign deq[i] = grant[i] && (count[i] != '0);

      assign head_entry[i] = (count[i] == '0) ? in_entry[i] : mem[head[i]];

      always_ff @(posedge clk) begin
        if (enq[i]) begin
          mem[tail[i]] <= in_entry[i];
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          count[i] <= '0;
          head[i]  <= '0;
          tail[i]  <= '0;
        end else if (flush) begin
          count[i] <= '0;
          head[i]  <= '0;
          tail[i]  <= '0;
        end else begin
          if (enq[i]) tail[i] <= ptr_inc(tail[i]);
          if (deq[i]) head[i] <= ptr_inc(head[i]);
          count[i] <= count[i] + CNT_W'(enq[i]) - CNT_W'(deq[i]);
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin scan order starting at rr_ptr
  // ---------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < NCH; k++) begin : g_scan
      logic [CH_W:0] sum;
      assign sum        = {1'b0, rr_ptr} + (CH_W+1)'(k);
      assign scan_ch[k] = (sum >= (CH_W+1)'(NCH)) ? CH_W'(sum - (CH_W+1)'(NCH))
                                                   : sum[CH_W-1:0];
    end
  endgenerate

  // Port p takes the p-th available channel in scan order.
  always_comb begin
    grant    = '0;
    port_vld = '0;
    for (int p = 0; p < NWP; p++) begin
      port_ch[p] = '0;
    end
    for (int p = 0; p < NWP; p++) begin
      for (int k = 0; k < NCH; k++) begin
        if (arb_en && !port_vld[p] && avail[scan_ch[k]] && !grant[scan_ch[k]]) begin
          port_vld[p]        = 1'b1;
          port_ch[p]         = scan_ch[k];
          grant[scan_ch[k]]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    last_ch = '0;
    for (int p = 0; p < NWP; p++) begin
      if (port_vld[p]) last_ch = port_ch[p];
    end
  end

  assign any_grant = port_vld[0];
  assign rr_next   = (({1'b0, last_ch} + 1'b1) == (CH_W+1)'(NCH)) ? '0 : last_ch + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (flush) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= rr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  generate
    for (genvar p = 0; p < NWP; p++) begin : g_port
      assign sel_entry[p] = port_vld[p] ? head_entry[port_ch[p]] : '0;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          out_valid[p]                  <= 1'b0;
          out_tag[p*TAG_W +: TAG_W]     <= '0;
          out_data[p*DATA_W +: DATA_W]  <= '0;
          out_ctrl[p*CTRL_W +: CTRL_W]  <= '0;
          out_ch[p*CH_W +: CH_W]        <= '0;
        end else if (flush) begin
          out_valid[p]                  <= 1'b0;
        end else if (!wb_stall) begin
          out_valid[p]                  <= port_vld[p];
          out_tag[p*TAG_W +: TAG_W]     <= sel_entry[p][E_W-1 -: TAG_W];
          out_data[p*DATA_W +: DATA_W]  <= sel_entry[p][CTRL_W +: DATA_W];
          out_ctrl[p*CTRL_W +: CTRL_W]  <= sel_entry[p][0 +: CTRL_W];
          out_ch[p*CH_W +: CH_W]        <= port_vld[p] ? port_ch[p] : '0;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire
